// File: rtl/fifo_ctrl_regpx.sv
// FIFO controller for an external 1R1W parity register array: pointer/count
// management, FWFT output buffer that hides the array read latency, and parity error capture.
module fifo_ctrl_regpx #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32,
    parameter int AFULL   = 496
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_vld,
    output logic               push_rdy,
    input  logic [WIDTH-1:0]   push_dat,
    output logic               pop_vld,
    input  logic               pop_rdy,
    output logic [WIDTH-1:0]   pop_dat,
    output logic               mem_we,
    output logic [ADDRBIT-1:0] mem_wa,
    output logic [WIDTH-1:0]   mem_di,
    output logic [ADDRBIT-1:0] mem_ra,
    input  logic [WIDTH-1:0]   mem_do,
    output logic [1:0]         mem_par_ctrl,
    input  logic               mem_par_err,
    input  logic               par_clr,
    input  logic               par_dis,
    output logic [ADDRBIT:0]   fifo_cnt,
    output logic               afull,
    output logic               par_err,
    output logic [ADDRBIT-1:0] par_err_addr
);

    localparam int CW = ADDRBIT + 1;
    localparam logic [ADDRBIT-1:0] LAST = ADDRBIT'(DEPTH - 1);

    logic [ADDRBIT-1:0] r_wptr;
    logic [ADDRBIT-1:0] r_rptr;
    logic [CW-1:0]      r_mcnt;
    logic               r_infl;
    logic [1:0]         r_ob_cnt;
    logic [WIDTH-1:0]   r_ob_head;
    logic [WIDTH-1:0]   r_ob_tail;
    logic [ADDRBIT-1:0] r_pa1;
    logic [ADDRBIT-1:0] r_pa2;
    logic [ADDRBIT-1:0] r_err_addr;
    logic               r_err_q;
    logic               r_captured;

    logic               w_accept;
    logic               w_issue;
    logic               w_pop;
    logic [2:0]         w_occ;

    assign push_rdy = !rst && (r_mcnt < CW'(DEPTH));
    assign w_accept = push_vld && push_rdy;

    assign mem_we = w_accept;
    assign mem_wa = r_wptr;
    assign mem_di = push_dat;
    assign mem_ra = r_rptr;

    assign pop_vld = (r_ob_cnt != 2'd0);
    assign pop_dat = r_ob_head;
    assign w_pop   = pop_vld && pop_rdy;

    // A same-cycle pop frees its buffer slot at this edge, so counting it keeps
    // the pop stream bubble-free while still never exceeding two buffered words.
    assign w_occ   = {1'b0, r_ob_cnt} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_issue = !rst && (r_mcnt != '0) && (w_occ < 3'd2);

    assign fifo_cnt = r_mcnt + CW'(r_infl) + CW'(r_ob_cnt);
    assign afull    = (fifo_cnt >= CW'(AFULL));

    assign mem_par_ctrl = {par_dis, par_clr};
    assign par_err      = mem_par_err;
    assign par_err_addr = r_err_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_mcnt   <= '0;
            r_infl   <= 1'b0;
            r_ob_cnt <= 2'd0;
        end else begin
            if (w_accept) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + ADDRBIT'(1);
            if (w_issue)  r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + ADDRBIT'(1);
            r_mcnt   <= r_mcnt + CW'(w_accept) - CW'(w_issue);
            r_infl   <= w_issue;
            r_ob_cnt <= r_ob_cnt + 2'(r_infl) - 2'(w_pop);
        end
    end

    // Head register drives pop_dat directly so it holds its value when the buffer empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ob_head <= '0;
            r_ob_tail <= '0;
        end else if (w_pop && r_ob_cnt == 2'd2) begin
            r_ob_head <= r_ob_tail;
            if (r_infl) r_ob_tail <= mem_do;
        end else if (r_infl) begin
            if (r_ob_cnt == 2'd0 || w_pop) r_ob_head <= mem_do;
            else                           r_ob_tail <= mem_do;
        end
    end

    // Read addresses are delayed two cycles to line up with the array's error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pa1      <= '0;
            r_pa2      <= '0;
            r_err_q    <= 1'b0;
            r_captured <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_pa1   <= r_rptr;
            r_pa2   <= r_pa1;
            r_err_q <= mem_par_err;
            if (par_clr) begin
                r_captured <= 1'b0;
                r_err_addr <= '0;
            end else if (mem_par_err && !r_err_q && !r_captured) begin
                r_captured <= 1'b1;
                r_err_addr <= r_pa2;
            end
        end
    end

endmodule
